sha_engine_arbiter: RTL and testbench
=====================================

// Module: sha_engine_arbiter
// PURPOSE
//  Shares one SHA engine (slave side of sha_engine_if) between N_REQ requesters.
//  - Round-robin arbitration; one request in flight at a time.
//  - Latches the winner's mode/msg and drives the engine valid/ready handshake.
//  - Returns the hash to the winner with a one-cycle done pulse.
// PARAMETERS
//  N_REQ          4     number of requesters, 2..16
//  TIMEOUT_CYCLES 4096  engine watchdog limit in BUSY; used only with SHA_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               asynchronous reset, active-high
//  req_valid  in   N_REQ           per-requester request, level; held until req_done
//  req_mode   in   N_REQ x mode_t  per-requester sha::mode_t
//  req_msg    in   N_REQ x msg_t   per-requester padded sha::msg_t block
//  req_grant  out  N_REQ           one-hot current owner; 0 when IDLE
//  req_done   out  N_REQ           one-cycle completion pulse to owner
//  req_err    out  1               qualifies req_done: 1 = aborted; tied 0 without macro
//  req_hash   out  hash_t          shared result bus; valid while any req_done bit is 1
//  eng_valid  out  1               to engine valid
//  eng_mode   out  mode_t          to engine mode
//  eng_msg    out  msg_t           to engine msg
//  eng_ready  in   1               from engine ready
//  eng_hash   in   hash_t          from engine hash; valid when eng_ready=1
//  busy       out  1               1 in BUSY or RESP
// BEHAVIOUR
//  - Reset values (async, immediate): state=IDLE, rr_ptr=0, req_grant=0, req_done=0,
//    req_err=0, req_hash=0, eng_valid=0, eng_mode=sha::sha1, eng_msg=0, busy=0.
//  - All outputs are registered.
//  - IDLE
//    - If any req_valid is 1, pick the first set bit searching from rr_ptr upward
//      with wrap (rr_ptr, rr_ptr+1 .. N_REQ-1, 0 ..).
//    - Latch the winner's mode/msg into eng_mode/eng_msg; set eng_valid=1 and
//      req_grant=onehot(winner); go BUSY.
//  - BUSY
//    - Hold eng_valid/eng_mode/eng_msg stable.
//    - On a clock edge with eng_valid & eng_ready: req_hash<=eng_hash, eng_valid<=0,
//      eng_mode<=sha1, eng_msg<=0; go RESP.
//  - RESP (exactly one cycle)
//    - req_done[winner]=1; req_grant is still asserted.
//    - Next edge: req_done=0, req_grant=0, rr_ptr<=(winner+1) mod N_REQ; go IDLE.
//  - The owner drops req_valid after sampling req_done. IDLE therefore always
//    spends at least one cycle before the next grant, which gives a 1-cycle bubble.
//  - Latency: req_valid seen in IDLE at edge E0 -> eng_valid high after E0.
//    With eng_ready at edge Ek, req_done is high for the cycle after Ek.
//    Minimum: 2 edges from sampled request to done.
//  - Boundary conditions
//    - req_valid of the owner dropped during BUSY: ignored; the transaction completes
//      and req_done still pulses.
//    - Requests arriving during BUSY/RESP: wait; they are not lost (level-sensitive).
//    - All N_REQ requesting continuously: each is served once per N_REQ grants.
//    - eng_ready high while not in BUSY: ignored.
//    - rr_ptr wraps from N_REQ-1 to 0.
//    - rst mid-transaction: all state cleared immediately; no req_done is issued.
//      The engine must be reset with the same rst.
//    - Simultaneous eng_ready and watchdog expiry: eng_ready wins (normal completion).
// CONFIGURATION
//  - SHA_ARB_TIMEOUT_EN defined:
//    - A counter clears on entry to BUSY and increments every BUSY cycle.
//    - On reaching TIMEOUT_CYCLES without eng_ready: eng_valid<=0, req_hash<=0,
//      req_err<=1; go RESP. req_done pulses with req_err=1 for that cycle.
//  - SHA_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; req_err is
//    constant 0.
// TESTING
//  - Reset: assert rst mid-BUSY -> all outputs at reset values the same cycle;
//    no req_done after release.
//  - Single request: req_valid[1]=1, sha256, engine ready 5 cycles after valid
//    -> req_grant=4'b0010, eng_msg=req_msg[1], req_hash=eng_hash, one req_done[1] pulse.
//  - Round-robin: req_valid=4'b1111 held -> grant order 0,1,2,3,0; exactly one
//    done per grant.
//  - Owner drops valid in BUSY: requester 2 deasserts 1 cycle after grant
//    -> transaction completes and req_done[2] pulses.
//  - Stability: eng_mode/eng_msg unchanged across 20 BUSY cycles while other
//    req_msg values toggle.
//  - With SHA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine never ready
//    -> req_done with req_err=1 and req_hash=0 after 16 BUSY cycles; next request
//    is then served normally.

Source files
------------

// File: rtl/sha_engine_arbiter.sv
// Round-robin arbiter sharing one SHA engine between N_REQ requesters, one request in flight.
// Optional engine watchdog enabled by defining SHA_ARB_TIMEOUT_EN.

package sha;
  typedef enum logic [1:0] {
    sha1   = 2'd0,
    sha224 = 2'd1,
    sha256 = 2'd2
  } mode_t;
  typedef logic [511:0] msg_t;
  typedef logic [255:0] hash_t;
endpackage

module sha_engine_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  sha::mode_t [N_REQ-1:0]  req_mode,
  input  sha::msg_t  [N_REQ-1:0]  req_msg,
  output logic [N_REQ-1:0]        req_grant,
  output logic [N_REQ-1:0]        req_done,
  output logic                    req_err,
  output sha::hash_t              req_hash,
  output logic                    eng_valid,
  output sha::mode_t              eng_mode,
  output sha::msg_t               eng_msg,
  input  logic                    eng_ready,
  input  sha::hash_t              eng_hash,
  output logic                    busy,
  output logic [1:0]              o_dbg_state
);

  // Engine handshake: eng_valid rises with the latched mode/msg and stays high with them
  // stable until an edge sees eng_valid & eng_ready; that edge transfers eng_hash.
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sha_engine_arbiter: N_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  state_t           r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_owner;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  sha::hash_t       r_hash;
  logic             r_eng_valid;
  sha::mode_t       r_eng_mode;
  sha::msg_t        r_eng_msg;
  logic             r_busy;

  logic             w_any;
  logic [IW-1:0]    w_pick;
  logic [IW-1:0]    w_next_ptr;

  assign w_any      = |req_valid;
  assign w_next_ptr = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);

  // Walk offsets from high to low so the requester closest to rr_ptr is kept last.
  always_comb begin : pick_winner
    logic [IW:0] v_idx;
    v_idx  = '0;
    w_pick = r_rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      v_idx = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (v_idx >= (IW+1)'(N_REQ)) v_idx = v_idx - (IW+1)'(N_REQ);
      if (req_valid[v_idx[IW-1:0]]) w_pick = v_idx[IW-1:0];
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;
  assign req_err = r_err;
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_hash      <= '0;
      r_eng_valid <= 1'b0;
      r_eng_mode  <= sha::sha1;
      r_eng_msg   <= '0;
      r_busy      <= 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner     <= w_pick;
            r_grant     <= N_REQ'(1) << w_pick;
            r_eng_valid <= 1'b1;
            r_eng_mode  <= req_mode[w_pick];
            r_eng_msg   <= req_msg[w_pick];
            r_busy      <= 1'b1;
            r_state     <= S_BUSY;
`ifdef SHA_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
          // eng_ready takes priority over a watchdog expiry on the same edge.
          if (r_eng_valid && eng_ready) begin
            r_hash      <= eng_hash;
            r_eng_valid <= 1'b0;
            r_eng_mode  <= sha::sha1;
            r_eng_msg   <= '0;
            r_done      <= r_grant;
            r_state     <= S_RESP;
          end
`ifdef SHA_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_hash      <= '0;
            r_eng_valid <= 1'b0;
            r_eng_mode  <= sha::sha1;
            r_eng_msg   <= '0;
            r_err       <= 1'b1;
            r_done      <= r_grant;
            r_state     <= S_RESP;
          end else begin
            r_tmo_cnt   <= r_tmo_cnt + TW'(1);
          end
`endif
        end
        S_RESP: begin
          r_done   <= '0;
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
          r_state  <= S_IDLE;
`ifdef SHA_ARB_TIMEOUT_EN
          r_err    <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_grant   = r_grant;
  assign req_done    = r_done;
  assign req_hash    = r_hash;
  assign eng_valid   = r_eng_valid;
  assign eng_mode    = r_eng_mode;
  assign eng_msg     = r_eng_msg;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sha_engine_arbiter.sv
// Directed bench for sha_engine_arbiter: engine responses feed an expected queue that is
// drained and checked when req_done pulses.

module tb_sha_engine_arbiter;
  localparam int N  = 4;
  localparam int HW = 256;
  localparam int EW = HW + 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  sha::mode_t [N-1:0]  req_mode;
  sha::msg_t  [N-1:0]  req_msg;
  logic [N-1:0]        req_grant;
  logic [N-1:0]        req_done;
  logic                req_err;
  sha::hash_t          req_hash;
  logic                eng_valid;
  sha::mode_t          eng_mode;
  sha::msg_t           eng_msg;
  logic                eng_ready;
  sha::hash_t          eng_hash;
  logic                busy;
  logic [1:0]          o_dbg_state;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  sha_engine_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_msg(req_msg),
    .req_grant(req_grant), .req_done(req_done), .req_err(req_err), .req_hash(req_hash),
    .eng_valid(eng_valid), .eng_mode(eng_mode), .eng_msg(eng_msg),
    .eng_ready(eng_ready), .eng_hash(eng_hash),
    .busy(busy), .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sha::msg_t rand_msg();
    sha::msg_t m;
    for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic sha::hash_t rand_hash();
    sha::hash_t h;
    for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++)
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, req_grant, 0);
    check({tag, "_done"}, req_done, 0);
    check({tag, "_err"}, req_err, 0);
    check({tag, "_hash"}, req_hash, 0);
    check({tag, "_eng_valid"}, eng_valid, 0);
    check({tag, "_eng_mode"}, eng_mode, sha::sha1);
    check({tag, "_eng_msg"}, eng_msg, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, o_dbg_state, 0);
  endtask

  // Called at a negedge right after the request inputs are set.
  task automatic start_txn(output int exp_who);
    int n;
    exp_who = pick(req_valid, exp_ptr);
    n = 0;
    while (req_grant == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", req_grant != '0, 1);
    check("grant_latency", n, 1);
    check("grant_onehot", req_grant, 4'b0001 << exp_who);
    check("eng_valid_up", eng_valid, 1);
    check("eng_msg_latched", eng_msg, req_msg[exp_who]);
    check("eng_mode_latched", eng_mode, req_mode[exp_who]);
    check("busy_up", busy, 1);
  endtask

  task automatic finish_txn(input int who, input int delay, input sha::hash_t h);
    logic [EW-1:0] e;
    int n;
    repeat (delay) @(negedge clk);
    eng_hash  = h;
    eng_ready = 1'b1;
    exp_q.push_back({4'(who), h});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_done == '0 && n < 8);
    eng_ready = 1'b0;
    eng_hash  = rand_hash();
    e = exp_q.pop_front();
    check("done_latency", n, 1);
    check("done_onehot", req_done, 4'b0001 << e[EW-1:HW]);
    check("done_hash", req_hash, e[HW-1:0]);
    check("done_err", req_err, 0);
    check("grant_in_resp", req_grant, 4'b0001 << e[EW-1:HW]);
    req_valid[who] = 1'b0;
    exp_ptr = (who + 1) % N;
    @(negedge clk);
    check("done_cleared", req_done, 0);
    check("grant_released", req_grant, 0);
    check("busy_down", busy, 0);
  endtask

  initial begin
    int who;
    sha::msg_t  saved_msg;
    sha::mode_t saved_mode;

    rst       = 1'b1;
    req_valid = '0;
    eng_ready = 1'b0;
    eng_hash  = '0;
    for (int i = 0; i < N; i++) begin
      req_mode[i] = sha::sha1;
      req_msg[i]  = rand_msg();
    end
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 1, engine answers 5 cycles after valid.
    req_mode[1]  = sha::sha256;
    req_msg[1]   = rand_msg();
    req_valid[1] = 1'b1;
    start_txn(who);
    check("single_grant", req_grant, 4'b0010);
    finish_txn(who, 4, rand_hash());

    // Reset in the middle of BUSY: immediate clear, no done afterwards.
    req_valid[3] = 1'b1;
    start_txn(who);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst          = 1'b0;
    req_valid[3] = 1'b0;
    exp_ptr      = 0;
    eng_ready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_done", req_done, 0);
      check("idle_ready_ignored", o_dbg_state, 0);
    end
    eng_ready = 1'b0;

    // All requesters held: expect 0,1,2,3 then wrap to 0.
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      start_txn(who);
      check("rr_order", who, k % N);
      finish_txn(who, $urandom_range(0, 3), rand_hash());
      if (k < 4) req_valid[who] = 1'b1;
    end
    req_valid = '0;

    // Owner drops its request one cycle into BUSY; completion must still be reported.
    req_valid[2] = 1'b1;
    start_txn(who);
    check("drop_owner", who, 2);
    @(negedge clk);
    req_valid[2] = 1'b0;
    finish_txn(2, 2, rand_hash());

    // Engine inputs stay stable while other requesters' inputs toggle.
    req_mode[0]  = sha::sha256;
    req_msg[0]   = rand_msg();
    saved_msg    = req_msg[0];
    saved_mode   = req_mode[0];
    req_valid[0] = 1'b1;
    start_txn(who);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("stable_msg", eng_msg, saved_msg);
      check("stable_mode", eng_mode, saved_mode);
      for (int j = 1; j < N; j++) begin
        req_msg[j]  = rand_msg();
        req_mode[j] = (c % 2 == 0) ? sha::sha224 : sha::sha1;
      end
    end
    finish_txn(0, 0, rand_hash());

`ifdef SHA_ARB_TIMEOUT_EN
    // Engine never answers: watchdog aborts after 16 BUSY cycles.
    begin
      int n;
      req_valid[1] = 1'b1;
      start_txn(who);
      n = 0;
      while (req_done == '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("tmo_cycles", n, 16);
      check("tmo_done", req_done, 4'b0010);
      check("tmo_err", req_err, 1);
      check("tmo_hash", req_hash, 0);
      check("tmo_eng_valid", eng_valid, 0);
      req_valid[1] = 1'b0;
      exp_ptr = 2;
      @(negedge clk);
      check("tmo_err_cleared", req_err, 0);
      check("tmo_done_cleared", req_done, 0);
      req_valid[3] = 1'b1;
      start_txn(who);
      check("tmo_next_owner", who, 3);
      finish_txn(3, 1, rand_hash());
    end
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
